// File: rtl/asrv32_stage_ctrl.sv
// ASRV32 multi-cycle stage sequencer: fetch, decode, execute, memory, writeback,
// with trap routing for illegal opcodes, data-bus errors and memory timeouts.
`ifndef ASRV32_OPCODES
`define ASRV32_OPCODES
`define OPCODE_WIDTH 11
`define RTYPE  0
`define ITYPE  1
`define LOAD   2
`define STORE  3
`define BRANCH 4
`define JAL    5
`define JALR   6
`define LUI    7
`define AUIPC  8
`define SYSTEM 9
`define FENCE  10
`endif

module asrv32_stage_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_en,
   input  logic [`OPCODE_WIDTH-1:0] i_opcode,
   input  logic [4:0]               i_rd_addr,
   input  logic                     i_imem_ack,
   input  logic                     i_dmem_ack,
   input  logic                     i_dmem_err,
   output logic                     o_imem_req,
   output logic                     o_dec_ce,
   output logic                     o_exe_ce,
   output logic                     o_dmem_req,
   output logic                     o_dmem_we,
   output logic                     o_rd_we,
   output logic                     o_pc_we,
   output logic                     o_instret,
   output logic                     o_trap,
   output logic [1:0]               o_trap_cause,
   output logic [31:0]              o_minstret,
   output logic [2:0]               o_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_TRAP      = 3'd6
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dmem_we_q;
   logic             rd_we_q;
   logic [1:0]       cause_q;
   logic [31:0]      minstret_q;

   logic illegal;
   logic is_mem;
   logic rd_we_dec;
   logic timeout;

   // A legal opcode has exactly one bit set: non-zero and clear of its lowest set bit.
   assign illegal   = (i_opcode == '0) ||
                      ((i_opcode & (i_opcode - `OPCODE_WIDTH'(1))) != '0);
   assign is_mem    = i_opcode[`LOAD] | i_opcode[`STORE];
   assign rd_we_dec = (i_rd_addr != 5'd0) &&
                      !(i_opcode[`STORE] | i_opcode[`BRANCH] |
                        i_opcode[`FENCE] | i_opcode[`SYSTEM]);
   assign timeout   = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         dmem_we_q  <= 1'b0;
         rd_we_q    <= 1'b0;
         cause_q    <= 2'd0;
         minstret_q <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (i_en) state_q <= S_FETCH;
            end
            S_FETCH: begin
               if (i_imem_ack) begin
                  state_q <= S_DECODE;
                  cnt_q   <= '0;
               end else if (timeout) begin
                  state_q <= S_TRAP;
                  cause_q <= 2'd3;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DECODE: state_q <= S_EXECUTE;
            S_EXECUTE: begin
               // Decoder outputs are registered by now; capture what later stages need.
               cnt_q     <= '0;
               dmem_we_q <= i_opcode[`STORE];
               rd_we_q   <= rd_we_dec;
               if (illegal) begin
                  state_q <= S_TRAP;
                  cause_q <= 2'd1;
               end else if (is_mem) begin
                  state_q <= S_MEMORY;
               end else begin
                  state_q <= S_WRITEBACK;
               end
            end
            S_MEMORY: begin
               if (i_dmem_err) begin
                  state_q <= S_TRAP;
                  cause_q <= 2'd2;
                  cnt_q   <= '0;
               end else if (i_dmem_ack) begin
                  state_q <= S_WRITEBACK;
                  cnt_q   <= '0;
               end else if (timeout) begin
                  state_q <= S_TRAP;
                  cause_q <= 2'd3;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_WRITEBACK: begin
               minstret_q <= minstret_q + 32'd1;
               cause_q    <= 2'd0;
               cnt_q      <= '0;
               state_q    <= i_en ? S_FETCH : S_IDLE;
            end
            S_TRAP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_imem_req   = (state_q == S_FETCH);
   assign o_dec_ce     = (state_q == S_DECODE);
   assign o_exe_ce     = (state_q == S_EXECUTE);
   assign o_dmem_req   = (state_q == S_MEMORY);
   assign o_dmem_we    = (state_q == S_MEMORY) && dmem_we_q;
   assign o_rd_we      = (state_q == S_WRITEBACK) && rd_we_q;
   assign o_pc_we      = (state_q == S_WRITEBACK);
   assign o_instret    = (state_q == S_WRITEBACK);
   assign o_trap       = (state_q == S_TRAP);
   assign o_trap_cause = cause_q;
   assign o_minstret   = minstret_q;
   assign o_state      = state_q;

endmodule
